// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction memory and holds the core in reset.
// Define IMEM_LOADER_CHECKSUM_EN to treat the last byte as a mod-256 checksum.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE,
    ERR
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t state;
  logic   xfer;
  logic   full;

  assign in_ready = (state == LOAD);
  assign xfer     = in_valid && in_ready;
  assign full     = (byte_count == DEPTH_C);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_next;
  assign sum_next = sum + in_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      byte_count <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_rst    <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        LOAD: begin
          if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum <= sum_next;
            // checksum byte is consumed but never stored
            if (in_last) begin
              if (sum_next == 8'd0) begin
                state   <= DONE;
                done    <= 1'b1;
                cpu_rst <= 1'b0;
              end else begin
                state <= ERR;
                err   <= 1'b1;
              end
            end else if (full) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              mem_we     <= 1'b1;
              mem_addr   <= byte_count[ADDR_W-1:0];
              mem_wdata  <= in_data;
              byte_count <= byte_count + 1'b1;
            end
`else
            if (full) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              mem_we     <= 1'b1;
              mem_addr   <= byte_count[ADDR_W-1:0];
              mem_wdata  <= in_data;
              byte_count <= byte_count + 1'b1;
              // release the core on the same edge as the final write
              if (in_last) begin
                state   <= DONE;
                done    <= 1'b1;
                cpu_rst <= 1'b0;
              end
            end
`endif
          end
        end
        default: begin
          if (start) begin
            state      <= LOAD;
            byte_count <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_rst    <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (DEPTH=16, ADDR_W=5).
// Checksum scenarios run only when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  localparam int AW = 5;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;
  logic [AW:0]   byte_count;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] wa[$];
  logic [7:0]    wd[$];
  logic          wc[$];

  logic [7:0] prog [12] = '{8'hb3, 8'h01, 8'h11, 8'h00, 8'h13, 8'h82,
                            8'h40, 8'h83, 8'h03, 8'h25, 8'h81, 8'h3e};

  imem_loader #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .done(done),
    .err(err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cpu_rst);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck 0, required 1");
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; in_valid = 0; in_data = 0; in_last = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({mem_we, done, err, in_ready, cpu_rst} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_flags: got we/done/err/rdy/crst=%b required 00001",
               {mem_we, done, err, in_ready, cpu_rst});
    end
    checks++;
    if (byte_count !== 6'd0 || mem_addr !== 5'd0 || mem_wdata !== 8'd0) begin
      errors++;
      $display("FAIL reset_regs: got cnt=%0d addr=%0d data=%h required 0/0/00",
               byte_count, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: in_ready=%b required 0", in_ready);
    end
  endtask

  task automatic check_prog_writes(input string tag);
    checks++;
    if (wa.size() != 12) begin
      errors++;
      $display("FAIL %s_count: got %0d writes required 12", tag, wa.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (wa[i] !== 5'(i) || wd[i] !== prog[i]) begin
          errors++;
          $display("FAIL %s_wr%0d: got addr=%0d data=%h required addr=%0d data=%h",
                   tag, i, wa[i], wd[i], i, prog[i]);
        end
      end
      checks++;
      if (wc[11] !== 1'b0 || wc[10] !== 1'b1) begin
        errors++;
        $display("FAIL %s_crst_edge: got last=%b prev=%b required 0 1",
                 tag, wc[11], wc[10]);
      end
    end
    checks++;
    if (byte_count !== 6'd12 || done !== 1'b1 || err !== 1'b0 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL %s_final: got cnt=%0d done=%b err=%b crst=%b required 12 1 0 0",
               tag, byte_count, done, err, cpu_rst);
    end
  endtask

  task automatic test_load();
    clear_log();
    pulse_start();
    for (int i = 0; i < 12; i++) send_byte(prog[i], i == 11);
    in_valid = 0; in_last = 0;
    tick();
    check_prog_writes("load");
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_ready_done: in_ready=%b required 0", in_ready);
    end
  endtask

  task automatic test_restart();
    clear_log();
    pulse_start();
    checks++;
    if (done !== 1'b0 || cpu_rst !== 1'b1 || byte_count !== 6'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_entry: got done=%b crst=%b cnt=%0d rdy=%b required 0 1 0 1",
               done, cpu_rst, byte_count, in_ready);
    end
    start = 1'b1;
    send_byte(8'haa, 1'b0);
    start = 1'b0;
    send_byte(8'hbb, 1'b1);
    in_valid = 0; in_last = 0;
    tick();
    checks++;
    if (wa.size() != 2 || wa[0] !== 5'd0 || wd[0] !== 8'haa ||
        wa[1] !== 5'd1 || wd[1] !== 8'hbb) begin
      errors++;
      $display("FAIL restart_writes: got n=%0d a0=%0d d0=%h a1=%0d d1=%h required 2 0 aa 1 bb",
               wa.size(), wa[0], wd[0], wa[1], wd[1]);
    end
    checks++;
    if (byte_count !== 6'd2 || done !== 1'b1 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL restart_final: got cnt=%0d done=%b crst=%b required 2 1 0",
               byte_count, done, cpu_rst);
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      send_byte(prog[i], i == 11);
      in_valid = 0; in_last = 0;
      tick();
      checks++;
      if (mem_we !== 1'b0) begin
        errors++;
        $display("FAIL bp_idle_we%0d: mem_we=%b required 0", i, mem_we);
      end
    end
    check_prog_writes("bp");
  endtask

  task automatic test_overflow();
    clear_log();
    pulse_start();
    for (int i = 0; i < 17; i++) send_byte(8'(8'h40 + i), 1'b0);
    in_valid = 0;
    tick();
    checks++;
    if (wa.size() != 16) begin
      errors++;
      $display("FAIL ovf_count: got %0d writes required 16", wa.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (wa[i] !== 5'(i) || wd[i] !== 8'(8'h40 + i)) begin
          errors++;
          $display("FAIL ovf_wr%0d: got addr=%0d data=%h required addr=%0d data=%h",
                   i, wa[i], wd[i], i, 8'h40 + i);
        end
      end
    end
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1 ||
        byte_count !== 6'd16 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_final: got err=%b done=%b crst=%b cnt=%0d rdy=%b required 1 0 1 16 0",
               err, done, cpu_rst, byte_count, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 1'b0);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 5'd4) begin
      errors++;
      $display("FAIL midrst_pre: got we=%b addr=%0d required 1 4", mem_we, mem_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0 || byte_count !== 6'd0 || cpu_rst !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: got we=%b cnt=%0d crst=%b rdy=%b required 0 0 1 0",
               mem_we, byte_count, cpu_rst, in_ready);
    end
    in_valid = 0;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b0 || byte_count !== 6'd0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: got rdy=%b cnt=%0d done=%b err=%b required 0 0 0 0",
               in_ready, byte_count, done, err);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_log();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hfd, 1'b1);
    in_valid = 0; in_last = 0;
    tick();
    checks++;
    if (wa.size() != 2 || wd[0] !== 8'h01 || wd[1] !== 8'h02 || wa[1] !== 5'd1) begin
      errors++;
      $display("FAIL csum_ok_writes: got n=%0d d0=%h d1=%h required 2 01 02",
               wa.size(), wd[0], wd[1]);
    end
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || byte_count !== 6'd2 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL csum_ok_final: got done=%b err=%b cnt=%0d crst=%b required 1 0 2 0",
               done, err, byte_count, cpu_rst);
    end
    clear_log();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hfe, 1'b1);
    in_valid = 0; in_last = 0;
    tick();
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1 || byte_count !== 6'd2) begin
      errors++;
      $display("FAIL csum_bad_final: got err=%b done=%b crst=%b cnt=%0d required 1 0 1 2",
               err, done, cpu_rst, byte_count);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef IMEM_LOADER_CHECKSUM_EN
    test_load();
    test_restart();
    test_backpressure();
`endif
    test_overflow();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the byte-addressed instruction memory. The processor core only reads that memory.
- Accepts a byte stream on a valid/ready interface and writes each byte, little-endian, to consecutive addresses from 0 upward.
- Holds the core in reset until the stream completes, then releases it.
- Sits between the host/debug byte source and the instruction-memory write port, beside the top-level core.

Parameters:
- ADDR_W, 10, byte address width of the instruction memory.
- DEPTH, 1024, number of bytes in the instruction memory; DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load session.
- in_valid  input  1  byte source has data.
- in_data  input  8  byte value.
- in_last  input  1  marks the final byte of the session; qualified by in_valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory byte write strobe.
- mem_addr  output  ADDR_W  write byte address.
- mem_wdata  output  8  write byte.
- cpu_rst  output  1  reset to the processor core (program counter, register write enable).
- done  output  1  load finished successfully.
- err  output  1  load aborted (overflow, or checksum failure with the option enabled).
- byte_count  output  ADDR_W+1  number of bytes accepted in the current session.

Behaviour:
- Reset: clock is clk; reset is rst, asynchronous and active-high.
  - State goes to IDLE. mem_we=0, mem_addr=0, mem_wdata=0, byte_count=0, done=0, err=0, in_ready=0, cpu_rst=1.
  - Reset asserted mid-load takes effect immediately and aborts the load. Any pending write is dropped (mem_we forced 0 asynchronously).
- States: IDLE, LOAD, DONE, ERR. All outputs are registered except in_ready, which is a decode of state==LOAD.
- IDLE:
  - cpu_rst=1. start -> LOAD, with byte_count cleared.
- LOAD:
  - cpu_rst=1, in_ready=1.
  - A transfer occurs when in_valid && in_ready.
  - On each transfer with byte_count < DEPTH: next cycle mem_we=1, mem_addr=byte_count[ADDR_W-1:0] (the pre-increment value), mem_wdata=in_data, and byte_count increments by 1. Write latency is one cycle from acceptance.
  - mem_we is a one-cycle pulse per accepted byte. Back-to-back transfers produce back-to-back write pulses.
  - A transfer with byte_count == DEPTH causes no write; next state is ERR.
  - A transfer with in_last=1 and no overflow: the byte is written, next state is DONE.
  - start during LOAD is ignored. in_last without in_valid is ignored.
- DONE:
  - cpu_rst=0, done=1, in_ready=0. byte_count holds its final value.
  - cpu_rst deasserts on the same clock edge that mem_we pulses for the final byte. The core's first fetch therefore sees the final byte written.
- ERR:
  - err=1, cpu_rst=1, in_ready=0. byte_count holds.
- Restart: start in DONE or ERR -> LOAD next cycle.
  - done and err clear, cpu_rst=1, byte_count=0.
  - Memory contents are not cleared; they are overwritten.
- Widths: byte_count is ADDR_W+1 bits so that the value DEPTH is representable. It does not wrap; it saturates at DEPTH.
- Simultaneous start and rst: rst wins.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - The in_last byte is a checksum byte and is not written to memory; byte_count does not count it.
  - The loader keeps an 8-bit running sum of all accepted bytes, including the checksum byte, modulo 256.
  - On in_last: sum == 0 -> DONE; otherwise -> ERR.
  - The sum clears on reset and on entry to LOAD.
- Disabled: the in_last byte is ordinary data, and no sum logic is built.

Test Plan:
- Load of 12 bytes:
  - Stimulus: reset, start, then stream b3 01 11 00 13 82 40 83 03 25 81 3e, in_last on the 12th byte.
  - Required: 12 mem_we pulses at addresses 0..11 carrying those bytes, byte_count=12, done=1, and cpu_rst falls on the edge of the final write.
- Back-pressure and gaps: same stream with in_valid toggling every other cycle -> identical writes, with no write on idle cycles.
- Overflow with DEPTH=16:
  - Stimulus: stream 17 bytes without in_last.
  - Required: 16 writes to addresses 0..15, then err=1, no 17th write, cpu_rst stays 1, byte_count=16.
- Mid-load reset: assert rst after the 5th byte is accepted -> mem_we=0 immediately, state IDLE, byte_count=0, cpu_rst=1.
- Restart after DONE: start again and stream 2 bytes aa bb with in_last -> writes to addresses 0 and 1, byte_count=2, done=1; start pulses during LOAD are ignored.
- Checksum (with IMEM_LOADER_CHECKSUM_EN):
  - Stream 01 02 fd -> DONE, 2 bytes written.
  - Stream 01 02 fe -> err=1.
